// File: rtl/systolic_feeder.sv
// systolic_feeder: gathers a 2x2 weight tile plus up to MAX_ROWS activation
// rows, then replays them into the 2x2 weight-stationary array. Weights are
// fed column-staggered, followed by a bank-switch pulse, and activations are
// fed row-staggered by one cycle.
module systolic_feeder #(
  parameter int DATA_W   = 16,
  parameter int MAX_ROWS = 8,
  parameter int CNT_W    = $clog2(MAX_ROWS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] w_in,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [DATA_W-1:0] a_in_0,
  input  logic [DATA_W-1:0] a_in_1,
  input  logic              a_valid,
  input  logic              a_last,
  output logic              a_ready,
  output logic [DATA_W-1:0] sys_data_in_11,
  output logic [DATA_W-1:0] sys_data_in_21,
  output logic              sys_start,
  output logic [DATA_W-1:0] sys_weight_in_11,
  output logic [DATA_W-1:0] sys_weight_in_12,
  output logic              sys_accept_w_1,
  output logic              sys_accept_w_2,
  output logic              sys_switch_in,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  row_count,
  output logic              trunc
);

  // Phase counter spans PUSH and STREAM: values 0..N+2, with N <= MAX_ROWS.
  localparam int PH_W = $clog2(MAX_ROWS + 3);

  typedef enum logic [2:0] {
    S_IDLE, S_W_COL, S_A_COL, S_PUSH, S_STREAM, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        widx_q, widx_d;
  logic [CNT_W-1:0]  row_count_q, row_count_d;
  logic [PH_W-1:0]   cyc_q, cyc_d;

  // Data buffers carry no reset; the FSM never drives them out unless valid.
  logic [DATA_W-1:0] wbuf_q [4];
  logic [DATA_W-1:0] rbuf0_q [MAX_ROWS];
  logic [DATA_W-1:0] rbuf1_q [MAX_ROWS];

  logic w_fire, a_fire, a_full, a_end, stream_end;
  logic in_push, in_run;
  logic [PH_W-1:0] n_ph, i11, i21;

  assign w_ready   = (state_q == S_IDLE) || (state_q == S_W_COL);
  assign a_ready   = (state_q == S_A_COL);
  assign w_fire    = w_valid && w_ready;
  assign a_fire    = a_valid && a_ready;
  assign a_full    = (row_count_q == CNT_W'(MAX_ROWS - 1));
  assign a_end     = a_fire && (a_last || a_full);
  assign trunc     = a_fire && !a_last && a_full;
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = (state_q == S_DONE);
  assign row_count = row_count_q;

  assign n_ph       = PH_W'(row_count_q);
  assign stream_end = (cyc_q == n_ph + PH_W'(2));
  assign in_push    = (state_q == S_PUSH);
  assign in_run     = in_push || (state_q == S_STREAM);
  assign i11        = cyc_q - PH_W'(2);
  assign i21        = cyc_q - PH_W'(3);

  // Next-state logic for the collect / push / stream sequence.
  always_comb begin
    state_d     = state_q;
    widx_d      = widx_q;
    row_count_d = row_count_q;
    cyc_d       = in_run ? cyc_q + PH_W'(1) : '0;
    if (w_fire) widx_d = widx_q + 2'd1;
    unique case (state_q)
      S_IDLE:   if (w_fire) state_d = S_W_COL;
      S_W_COL: begin
        if (w_fire && widx_q == 2'd3) begin
          state_d     = S_A_COL;
          row_count_d = '0;  // fresh tile: never reuse stale rows
        end
      end
      S_A_COL: begin
        if (a_fire) row_count_d = row_count_q + CNT_W'(1);
        if (a_end)  state_d = S_PUSH;
      end
      S_PUSH:   if (cyc_q == PH_W'(2)) state_d = S_STREAM;
      S_STREAM: if (stream_end) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      widx_q      <= '0;
      row_count_q <= '0;
      cyc_q       <= '0;
    end else begin
      state_q     <= state_d;
      widx_q      <= widx_d;
      row_count_q <= row_count_d;
      cyc_q       <= cyc_d;
    end
  end

  // Capture weight and activation elements on their handshakes.
  always_ff @(posedge clk) begin
    if (w_fire) wbuf_q[widx_q] <= w_in;
    for (int r = 0; r < MAX_ROWS; r++) begin
      if (a_fire && row_count_q == CNT_W'(r)) begin
        rbuf0_q[r] <= a_in_0;
        rbuf1_q[r] <= a_in_1;
      end
    end
  end

  // Weight replay: column 1 gets W10 then W00, column 2 gets W11 then W01,
  // one cycle later, followed by the bank switch on the last weight beat.
  always_comb begin
    sys_accept_w_1   = 1'b0;
    sys_accept_w_2   = 1'b0;
    sys_switch_in    = 1'b0;
    sys_weight_in_11 = '0;
    sys_weight_in_12 = '0;
    if (in_push) begin
      unique case (cyc_q)
        PH_W'(0): begin
          sys_accept_w_1   = 1'b1;
          sys_weight_in_11 = wbuf_q[2];
        end
        PH_W'(1): begin
          sys_accept_w_1   = 1'b1;
          sys_weight_in_11 = wbuf_q[0];
          sys_accept_w_2   = 1'b1;
          sys_weight_in_12 = wbuf_q[3];
        end
        PH_W'(2): begin
          sys_accept_w_2   = 1'b1;
          sys_weight_in_12 = wbuf_q[1];
          sys_switch_in    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Activation replay: row 1 starts at phase 2, row 2 trails by one cycle.
  always_comb begin
    sys_start      = 1'b0;
    sys_data_in_11 = '0;
    sys_data_in_21 = '0;
    if (in_run && cyc_q >= PH_W'(2) && cyc_q <= n_ph + PH_W'(1)) begin
      sys_start = 1'b1;
      for (int r = 0; r < MAX_ROWS; r++)
        if (i11 == PH_W'(r)) sys_data_in_11 = rbuf0_q[r];
    end
    if (in_run && cyc_q >= PH_W'(3) && cyc_q <= n_ph + PH_W'(2)) begin
      for (int r = 0; r < MAX_ROWS; r++)
        if (i21 == PH_W'(r)) sys_data_in_21 = rbuf1_q[r];
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: inputs change 1 time unit after the
// rising edge, outputs are sampled on the falling edge.
module tb_systolic_feeder;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] w_in, a_in_0, a_in_1;
  logic        w_valid, a_valid, a_last;
  logic        w_ready, a_ready, sys_start, sys_accept_w_1, sys_accept_w_2;
  logic        sys_switch_in, busy, done, trunc;
  logic [15:0] sys_data_in_11, sys_data_in_21, sys_weight_in_11, sys_weight_in_12;
  logic [3:0]  row_count;
  int checks = 0;
  int errors = 0;

  systolic_feeder #(.DATA_W(16), .MAX_ROWS(8)) dut (
    .clk(clk), .rst(rst),
    .w_in(w_in), .w_valid(w_valid), .w_ready(w_ready),
    .a_in_0(a_in_0), .a_in_1(a_in_1), .a_valid(a_valid), .a_last(a_last),
    .a_ready(a_ready),
    .sys_data_in_11(sys_data_in_11), .sys_data_in_21(sys_data_in_21),
    .sys_start(sys_start),
    .sys_weight_in_11(sys_weight_in_11), .sys_weight_in_12(sys_weight_in_12),
    .sys_accept_w_1(sys_accept_w_1), .sys_accept_w_2(sys_accept_w_2),
    .sys_switch_in(sys_switch_in),
    .busy(busy), .done(done), .row_count(row_count), .trunc(trunc)
  );

  always #5 clk = ~clk;

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic smp();  @(negedge clk); endtask

  task automatic load_w(input logic [15:0] a, b, c, d);
    logic [15:0] w [4];
    w[0] = a; w[1] = b; w[2] = c; w[3] = d;
    for (int i = 0; i < 4; i++) begin
      w_in = w[i]; w_valid = 1'b1; tick();
    end
    w_valid = 1'b0; w_in = '0;
  endtask

  task automatic push_row(input logic [15:0] x0, x1, input logic last);
    a_in_0 = x0; a_in_1 = x1; a_valid = 1'b1; a_last = last;
    tick();
    a_valid = 1'b0; a_last = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; w_in = '0; w_valid = 0; a_in_0 = '0; a_in_1 = '0; a_valid = 0; a_last = 0;
    tick(); tick();
    smp();
    checks++; if (w_ready !== 1'b1) begin errors++; $display("FAIL rst_w_ready got %b exp 1", w_ready); end
    tick(); rst = 1'b0;
    smp();
    checks++; if (w_ready !== 1'b1) begin errors++; $display("FAIL idle_w_ready got %b exp 1", w_ready); end
    checks++; if ({a_ready, busy, done, trunc, sys_start} !== 5'b0) begin errors++; $display("FAIL rst_ctrl got %b exp 00000", {a_ready, busy, done, trunc, sys_start}); end
    checks++; if ({sys_accept_w_1, sys_accept_w_2, sys_switch_in} !== 3'b0) begin errors++; $display("FAIL rst_wctl got %b exp 000", {sys_accept_w_1, sys_accept_w_2, sys_switch_in}); end
    checks++; if ({sys_data_in_11, sys_data_in_21, sys_weight_in_11, sys_weight_in_12} !== 64'h0) begin errors++; $display("FAIL rst_data got %h exp 0", {sys_data_in_11, sys_data_in_21, sys_weight_in_11, sys_weight_in_12}); end
    checks++; if (row_count !== 4'd0) begin errors++; $display("FAIL rst_row_count got %0d exp 0", row_count); end
  endtask

  task automatic test_basic();
    load_w(16'h0100, 16'h0000, 16'h0000, 16'h0100);
    smp();
    checks++; if ({busy, a_ready, w_ready} !== 3'b110) begin errors++; $display("FAIL basic_acol got %b exp 110", {busy, a_ready, w_ready}); end
    push_row(16'h0100, 16'h0200, 1'b0);
    push_row(16'h0300, 16'h0400, 1'b1);
    smp(); // t0
    checks++; if ({sys_accept_w_1, sys_accept_w_2, sys_start} !== 3'b100) begin errors++; $display("FAIL basic_t0_ctl got %b exp 100", {sys_accept_w_1, sys_accept_w_2, sys_start}); end
    checks++; if (sys_weight_in_11 !== 16'h0000) begin errors++; $display("FAIL basic_t0_w11 got %h exp 0000", sys_weight_in_11); end
    tick(); smp(); // t1
    checks++; if ({sys_accept_w_1, sys_accept_w_2} !== 2'b11) begin errors++; $display("FAIL basic_t1_ctl got %b exp 11", {sys_accept_w_1, sys_accept_w_2}); end
    checks++; if (sys_weight_in_11 !== 16'h0100) begin errors++; $display("FAIL basic_t1_w11 got %h exp 0100", sys_weight_in_11); end
    tick(); smp(); // t2
    checks++; if ({sys_accept_w_1, sys_accept_w_2, sys_switch_in, sys_start} !== 4'b0111) begin errors++; $display("FAIL basic_t2_ctl got %b exp 0111", {sys_accept_w_1, sys_accept_w_2, sys_switch_in, sys_start}); end
    checks++; if ({sys_data_in_11, sys_data_in_21} !== {16'h0100, 16'h0000}) begin errors++; $display("FAIL basic_t2_data got %h exp 01000000", {sys_data_in_11, sys_data_in_21}); end
    tick(); smp(); // t3
    checks++; if ({sys_data_in_11, sys_data_in_21} !== {16'h0300, 16'h0200}) begin errors++; $display("FAIL basic_t3_data got %h exp 03000200", {sys_data_in_11, sys_data_in_21}); end
    checks++; if ({sys_start, sys_switch_in} !== 2'b10) begin errors++; $display("FAIL basic_t3_ctl got %b exp 10", {sys_start, sys_switch_in}); end
    tick(); smp(); // t4
    checks++; if ({sys_data_in_11, sys_data_in_21} !== {16'h0000, 16'h0400}) begin errors++; $display("FAIL basic_t4_data got %h exp 00000400", {sys_data_in_11, sys_data_in_21}); end
    checks++; if ({sys_start, done} !== 2'b00) begin errors++; $display("FAIL basic_t4_ctl got %b exp 00", {sys_start, done}); end
    tick(); smp(); // t5
    checks++; if ({done, busy} !== 2'b10) begin errors++; $display("FAIL basic_t5_done got %b exp 10", {done, busy}); end
    checks++; if (row_count !== 4'd2) begin errors++; $display("FAIL basic_row_count got %0d exp 2", row_count); end
    tick(); smp();
    checks++; if ({done, w_ready} !== 2'b01) begin errors++; $display("FAIL basic_idle got %b exp 01", {done, w_ready}); end
  endtask

  // Weights offered every other cycle; a_valid in W_COL and w_valid in A_COL
  // must both be ignored. Then a single row tile.
  task automatic test_toggle_single();
    logic [15:0] w [4];
    w[0] = 16'h1111; w[1] = 16'h2222; w[2] = 16'h3333; w[3] = 16'h4444;
    for (int i = 0; i < 4; i++) begin
      w_in = w[i]; w_valid = 1'b1; tick();
      w_valid = 1'b0; w_in = 16'hDEAD;
      smp();
      checks++; if (w_ready !== (i < 3)) begin errors++; $display("FAIL tog_w_ready_%0d got %b exp %b", i, w_ready, (i < 3)); end
      a_in_0 = 16'h7777; a_in_1 = 16'h7777; a_valid = (i < 3);
      tick(); a_valid = 1'b0;
    end
    smp();
    checks++; if ({a_ready, row_count} !== {1'b1, 4'd0}) begin errors++; $display("FAIL tog_acol got %b/%0d exp 1/0", a_ready, row_count); end
    w_valid = 1'b1; w_in = 16'hBEEF;
    push_row(16'hFF80, 16'h0080, 1'b1);
    w_valid = 1'b0;
    smp(); // t0
    checks++; if ({sys_weight_in_11, sys_weight_in_12} !== {16'h3333, 16'h0000}) begin errors++; $display("FAIL tog_t0_w got %h exp 33330000", {sys_weight_in_11, sys_weight_in_12}); end
    tick(); smp(); // t1
    checks++; if ({sys_weight_in_11, sys_weight_in_12} !== {16'h1111, 16'h4444}) begin errors++; $display("FAIL tog_t1_w got %h exp 11114444", {sys_weight_in_11, sys_weight_in_12}); end
    tick(); smp(); // t2
    checks++; if ({sys_weight_in_11, sys_weight_in_12} !== {16'h0000, 16'h2222}) begin errors++; $display("FAIL tog_t2_w got %h exp 00002222", {sys_weight_in_11, sys_weight_in_12}); end
    checks++; if ({sys_data_in_11, sys_data_in_21, sys_start, sys_switch_in} !== {16'hFF80, 16'h0000, 2'b11}) begin errors++; $display("FAIL single_t2 got %h/%b exp ff800000/11", {sys_data_in_11, sys_data_in_21}, {sys_start, sys_switch_in}); end
    tick(); smp(); // t3
    checks++; if ({sys_data_in_11, sys_data_in_21, sys_start} !== {16'h0000, 16'h0080, 1'b0}) begin errors++; $display("FAIL single_t3 got %h/%b exp 00000080/0", {sys_data_in_11, sys_data_in_21}, sys_start); end
    checks++; if ({sys_weight_in_12, sys_switch_in, done} !== {16'h0000, 2'b00}) begin errors++; $display("FAIL single_t3_ctl got %h/%b exp 0000/00", sys_weight_in_12, {sys_switch_in, done}); end
    tick(); smp(); // t4
    checks++; if ({done, sys_data_in_21, row_count} !== {1'b1, 16'h0000, 4'd1}) begin errors++; $display("FAIL single_t4 got %b/%h/%0d exp 1/0000/1", done, sys_data_in_21, row_count); end
    tick();
  endtask

  task automatic test_trunc();
    logic [15:0] e11, e21;
    load_w(16'h0001, 16'h0002, 16'h0003, 16'h0004);
    for (int r = 0; r < 8; r++) begin
      a_in_0 = 16'h1000 + 16'(r); a_in_1 = 16'h2000 + 16'(r); a_valid = 1'b1; a_last = 1'b0;
      smp();
      checks++; if (trunc !== (r == 7)) begin errors++; $display("FAIL trunc_row%0d got %b exp %b", r, trunc, (r == 7)); end
      tick();
    end
    a_valid = 1'b0;
    smp(); // t0
    checks++; if ({a_ready, trunc, row_count} !== {2'b00, 4'd8}) begin errors++; $display("FAIL trunc_after got %b/%0d exp 00/8", {a_ready, trunc}, row_count); end
    for (int t = 0; t < 12; t++) begin
      e11 = (t >= 2 && t <= 9)  ? 16'h1000 + 16'(t - 2) : 16'h0000;
      e21 = (t >= 3 && t <= 10) ? 16'h2000 + 16'(t - 3) : 16'h0000;
      if (t > 0) begin tick(); smp(); end
      checks++; if (sys_start !== (t >= 2 && t <= 9)) begin errors++; $display("FAIL trunc_start_t%0d got %b", t, sys_start); end
      checks++; if (sys_data_in_11 !== e11) begin errors++; $display("FAIL trunc_d11_t%0d got %h exp %h", t, sys_data_in_11, e11); end
      checks++; if (sys_data_in_21 !== e21) begin errors++; $display("FAIL trunc_d21_t%0d got %h exp %h", t, sys_data_in_21, e21); end
      checks++; if (done !== (t == 11)) begin errors++; $display("FAIL trunc_done_t%0d got %b exp %b", t, done, (t == 11)); end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    load_w(16'h0005, 16'h0006, 16'h0007, 16'h0008);
    push_row(16'h00A0, 16'h00A1, 1'b0);
    push_row(16'h00B0, 16'h00B1, 1'b0);
    push_row(16'h00C0, 16'h00C1, 1'b1);
    tick(); tick(); tick(); smp(); // t3, k=1
    checks++; if ({sys_data_in_11, sys_data_in_21} !== {16'h00B0, 16'h00A1}) begin errors++; $display("FAIL rmid_k1 got %h exp 00b000a1", {sys_data_in_11, sys_data_in_21}); end
    rst = 1'b1; tick(); rst = 1'b0; smp();
    checks++; if ({w_ready, a_ready, busy, done, sys_start, sys_switch_in, sys_accept_w_1, sys_accept_w_2} !== 8'b1000_0000) begin errors++; $display("FAIL rmid_ctl got %b exp 10000000", {w_ready, a_ready, busy, done, sys_start, sys_switch_in, sys_accept_w_1, sys_accept_w_2}); end
    checks++; if ({sys_data_in_11, sys_data_in_21, sys_weight_in_11, sys_weight_in_12} !== 64'h0) begin errors++; $display("FAIL rmid_data got %h exp 0", {sys_data_in_11, sys_data_in_21, sys_weight_in_11, sys_weight_in_12}); end
    checks++; if (row_count !== 4'd0) begin errors++; $display("FAIL rmid_row_count got %0d exp 0", row_count); end
    for (int i = 0; i < 3; i++) begin
      tick(); smp();
      checks++; if ({done, busy, sys_start} !== 3'b000) begin errors++; $display("FAIL rmid_quiet_%0d got %b exp 000", i, {done, busy, sys_start}); end
    end
    load_w(16'h0011, 16'h0022, 16'h0033, 16'h0044);
    push_row(16'h0055, 16'h0066, 1'b1);
    smp();
    checks++; if ({sys_accept_w_1, sys_weight_in_11} !== {1'b1, 16'h0033}) begin errors++; $display("FAIL rmid_t0 got %b/%h exp 1/0033", sys_accept_w_1, sys_weight_in_11); end
    tick(); smp();
    checks++; if ({sys_weight_in_11, sys_weight_in_12} !== {16'h0011, 16'h0044}) begin errors++; $display("FAIL rmid_t1 got %h exp 00110044", {sys_weight_in_11, sys_weight_in_12}); end
    tick(); smp();
    checks++; if ({sys_weight_in_12, sys_data_in_11} !== {16'h0022, 16'h0055}) begin errors++; $display("FAIL rmid_t2 got %h exp 00220055", {sys_weight_in_12, sys_data_in_11}); end
    tick(); smp();
    checks++; if (sys_data_in_21 !== 16'h0066) begin errors++; $display("FAIL rmid_t3 got %h exp 0066", sys_data_in_21); end
    tick(); smp();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL rmid_done got %b exp 1", done); end
    tick();
  endtask

  task automatic test_back_to_back();
    load_w(16'h0100, 16'h0200, 16'h0300, 16'h0400);
    push_row(16'h0001, 16'h0002, 1'b0);
    push_row(16'h0003, 16'h0004, 1'b1);
    tick(); tick(); tick(); tick(); tick(); smp(); // t5
    checks++; if ({done, w_ready} !== 2'b10) begin errors++; $display("FAIL b2b_done got %b exp 10", {done, w_ready}); end
    w_in = 16'h0AAA; w_valid = 1'b1;
    tick(); smp(); // IDLE: weight offered since DONE is taken this cycle
    checks++; if ({w_ready, busy, done} !== 3'b100) begin errors++; $display("FAIL b2b_idle got %b exp 100", {w_ready, busy, done}); end
    tick(); smp();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b exp 1", busy); end
    w_in = 16'h0BBB; tick();
    w_in = 16'h0CCC; tick();
    w_in = 16'h0DDD; tick();
    w_valid = 1'b0; smp();
    checks++; if ({a_ready, row_count} !== {1'b1, 4'd0}) begin errors++; $display("FAIL b2b_acol got %b/%0d exp 1/0", a_ready, row_count); end
    push_row(16'h0E0E, 16'h0F0F, 1'b1);
    smp();
    checks++; if (sys_weight_in_11 !== 16'h0CCC) begin errors++; $display("FAIL b2b_t0 got %h exp 0ccc", sys_weight_in_11); end
    tick(); smp();
    checks++; if ({sys_weight_in_11, sys_weight_in_12} !== {16'h0AAA, 16'h0DDD}) begin errors++; $display("FAIL b2b_t1 got %h exp 0aaa0ddd", {sys_weight_in_11, sys_weight_in_12}); end
    tick(); smp();
    checks++; if ({sys_weight_in_12, sys_data_in_11} !== {16'h0BBB, 16'h0E0E}) begin errors++; $display("FAIL b2b_t2 got %h exp 0bbb0e0e", {sys_weight_in_12, sys_data_in_11}); end
    tick(); smp();
    checks++; if ({sys_data_in_11, sys_data_in_21} !== {16'h0000, 16'h0F0F}) begin errors++; $display("FAIL b2b_t3 got %h exp 00000f0f", {sys_data_in_11, sys_data_in_21}); end
    tick(); smp();
    checks++; if ({done, row_count} !== {1'b1, 4'd1}) begin errors++; $display("FAIL b2b_t4 got %b/%0d exp 1/1", done, row_count); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_toggle_single();
    test_trunc();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
